// File: rtl/tristate_bus_arbiter_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// tristate_bus_arbiter_pkg : shared state encoding and counter widths
// Rev 1.0
// ------------------------------------------------------------------
package tristate_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      TURN  = 2'd2
   } state_t;

   localparam int c_hold_w = 8;
   localparam int c_turn_w = 4;

endpackage
`default_nettype wire

// File: rtl/tristate_bus_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------
// tristate_bus_arbiter_if : request/grant signals of the bus arbiter
// Rev 1.0
// ------------------------------------------------------------------
interface tristate_bus_arbiter_if #(
   parameter int WIDTH = 16,
   parameter int NCH   = 4
);
   logic [NCH-1:0]       req;
   logic [NCH*WIDTH-1:0] din;
   logic [NCH-1:0]       oe_n;
   logic [NCH-1:0]       gnt;
   logic [WIDTH-1:0]     bus_q;
   logic                 busy;

   // master is the arbiter that owns the bus; slave is the requester side
   modport master (input req, din, output oe_n, gnt, bus_q, busy);
   modport slave  (output req, din, input oe_n, gnt, bus_q, busy);
endinterface
`default_nettype wire

// File: rtl/tristate_bus_arbiter_rr_pick.sv
`default_nettype none
// ------------------------------------------------------------------
// tristate_bus_arbiter_rr_pick : combinational round-robin selector
// Rev 1.0
// ------------------------------------------------------------------
module tristate_bus_arbiter_rr_pick #(
   parameter int NCH   = 4,
   parameter int IDX_W = 2
) (
   input  wire logic [NCH-1:0]   i_req,
   input  wire logic [IDX_W-1:0] i_rr_ptr,
   output logic [NCH-1:0]        o_sel,
   output logic [IDX_W-1:0]      o_owner,
   output logic                  o_any
);
   logic [IDX_W-1:0] w_idx;

   // Scan farthest-first so the channel nearest after the pointer is written last and wins.
   always_comb begin
      o_sel   = '0;
      o_owner = '0;
      o_any   = 1'b0;
      w_idx   = '0;
      for (int k = NCH; k >= 1; k--) begin
         w_idx = IDX_W'((int'(i_rr_ptr) + k) % NCH);
         if (i_req[w_idx]) begin
            o_sel        = '0;
            o_sel[w_idx] = 1'b1;
            o_owner      = w_idx;
            o_any        = 1'b1;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/tristate_bus_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tristate_bus_arbiter : round-robin owner of a shared tristate bus
// Rev 1.0
// ------------------------------------------------------------------
module tristate_bus_arbiter
   import tristate_bus_arbiter_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int NCH        = 4,
   parameter int TURNAROUND = 1,
   parameter int MAX_HOLD   = 8
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   inout  wire [WIDTH-1:0]        bus,
   tristate_bus_arbiter_if.master arb
);
   localparam int c_idx_w = $clog2(NCH);

   state_t              r_state;
   logic [c_idx_w-1:0]  r_ptr;
   logic [c_idx_w-1:0]  r_owner;
   logic [c_hold_w-1:0] r_hold;
   logic [c_turn_w-1:0] r_turn;
   logic [NCH-1:0]      r_gnt;
   logic [NCH-1:0]      r_oe_n;
   logic [WIDTH-1:0]    r_bus_q;
   logic                r_busy;

   logic [NCH-1:0]      w_sel;
   logic [c_idx_w-1:0]  w_owner;
   logic                w_any;
   logic                w_arbitrate;
   logic                w_release;

   tristate_bus_arbiter_rr_pick #(
      .NCH   (NCH),
      .IDX_W (c_idx_w)
   ) u_rr_pick (
      .i_req    (arb.req),
      .i_rr_ptr (r_ptr),
      .o_sel    (w_sel),
      .o_owner  (w_owner),
      .o_any    (w_any)
   );

   assign w_arbitrate = (r_state == IDLE) || ((r_state == TURN) && (r_turn == '0));
   // Owner drops its request, or its hold budget is spent while someone else waits.
   assign w_release   = !arb.req[r_owner] ||
                        ((r_hold == c_hold_w'(MAX_HOLD - 1)) && ((arb.req & ~r_gnt) != '0));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= c_idx_w'(NCH - 1);
         r_owner <= '0;
         r_hold  <= '0;
         r_turn  <= '0;
         r_gnt   <= '0;
         r_oe_n  <= '1;
         r_busy  <= 1'b0;
         r_bus_q <= '0;
      end else begin
         r_bus_q <= bus;
         case (r_state)
            DRIVE: begin
               if (w_release) begin
                  r_state <= TURN;
                  r_gnt   <= '0;
                  r_oe_n  <= '1;
                  r_turn  <= c_turn_w'(TURNAROUND - 1);
               end else if (r_hold != '1) begin
                  r_hold <= r_hold + c_hold_w'(1);
               end
            end
            TURN: begin
               if (r_turn != '0) begin
                  r_turn <= r_turn - c_turn_w'(1);
               end else if (!w_any) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            IDLE: begin
            end
            default: begin
               r_state <= IDLE;
               r_gnt   <= '0;
               r_oe_n  <= '1;
               r_busy  <= 1'b0;
            end
         endcase
         if (w_arbitrate && w_any) begin
            r_state <= DRIVE;
            r_gnt   <= w_sel;
            r_oe_n  <= ~w_sel;
            r_ptr   <= w_owner;
            r_owner <= w_owner;
            r_hold  <= '0;
            r_busy  <= 1'b1;
         end
      end
   end

   assign bus       = (r_state == DRIVE) ? arb.din[int'(r_owner) * WIDTH +: WIDTH] : {WIDTH{1'bz}};
   assign arb.oe_n  = r_oe_n;
   assign arb.gnt   = r_gnt;
   assign arb.bus_q = r_bus_q;
   assign arb.busy  = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_tristate_bus_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_tristate_bus_arbiter : scoreboard bench, TURNAROUND 1 and 3 instances
// Rev 1.0
// ------------------------------------------------------------------
module tb_tristate_bus_arbiter;
   localparam int W  = 16;
   localparam int N  = 4;
   localparam int MH = 8;

   logic           clk   = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req   = '0;
   logic [N*W-1:0] din   = '0;
   bit             sel_b = 1'b0;
   int             checks   = 0;
   int             failures = 0;
   wire [W-1:0]    bus_a;
   wire [W-1:0]    bus_b;

   always #5 clk = ~clk;

   tristate_bus_arbiter_if #(.WIDTH(W), .NCH(N)) ifa ();
   tristate_bus_arbiter_if #(.WIDTH(W), .NCH(N)) ifb ();
   assign ifa.req = req;
   assign ifa.din = din;
   assign ifb.req = req;
   assign ifb.din = din;

   tristate_bus_arbiter #(.WIDTH(W), .NCH(N), .TURNAROUND(1), .MAX_HOLD(MH)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a), .arb(ifa));
   tristate_bus_arbiter #(.WIDTH(W), .NCH(N), .TURNAROUND(3), .MAX_HOLD(MH)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b), .arb(ifb));

   wire [N-1:0] o_gnt  = sel_b ? ifb.gnt   : ifa.gnt;
   wire [N-1:0] o_oe_n = sel_b ? ifb.oe_n  : ifa.oe_n;
   wire         o_busy = sel_b ? ifb.busy  : ifa.busy;
   wire [W-1:0] o_bq   = sel_b ? ifb.bus_q : ifa.bus_q;
   wire [W-1:0] o_bus  = sel_b ? bus_b     : bus_a;

   typedef struct {
      logic [N-1:0] gnt;
      logic [N-1:0] oe_n;
      logic         busy;
      bit           bus_chk;
      logic [W-1:0] bus;
      bit           bq_chk;
      logic [W-1:0] bq;
   } exp_t;
   exp_t sbq[$];

   // reference model state: 0 idle, 1 drive, 2 turnaround
   int m_state = 0, m_owner = -1, m_ptr = N - 1, m_hold = 0, m_turn = 0, m_ta = 1;

   int own_log[$];
   int len_log[$];
   int gap_log[$];
   int run_len = 0;
   int gap     = 1000;
   logic [N-1:0] last_g = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int ptr);
      for (int k = 1; k <= N; k++) begin
         if (r[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic model_edge(input logic [N-1:0] r);
      int p;
      logic [N-1:0] others;
      if (!rst_n) begin
         m_state = 0; m_owner = -1; m_ptr = N - 1; m_hold = 0; m_turn = 0;
         return;
      end
      p = pick(r, m_ptr);
      if (m_state == 1) begin
         others = r;
         others[m_owner] = 1'b0;
         if (!r[m_owner] || (m_hold == MH - 1 && others != 0)) begin
            m_state = 2; m_owner = -1; m_turn = m_ta - 1;
         end else if (m_hold < 255) begin
            m_hold++;
         end
      end else if (m_state == 2 && m_turn > 0) begin
         m_turn--;
      end else if (p >= 0) begin
         m_state = 1; m_owner = p; m_ptr = p; m_hold = 0;
      end else begin
         m_state = 0;
      end
   endtask

   // One clock: drive inputs, push the model's prediction, then pop and compare after the edge.
   task automatic cycle(input logic [N-1:0] r, input logic [N*W-1:0] d);
      exp_t e;
      bit pd;
      int po;
      req = r;
      din = d;
      pd = (m_state == 1);
      po = m_owner;
      model_edge(r);
      e.gnt     = '0;
      e.bus     = '0;
      e.bq      = '0;
      e.bus_chk = (m_state == 1);
      if (m_state == 1) begin
         e.gnt[m_owner] = 1'b1;
         e.bus = d[m_owner*W +: W];
      end
      e.oe_n   = ~e.gnt;
      e.busy   = (m_state != 0);
      e.bq_chk = !rst_n || pd;
      if (rst_n && pd) e.bq = d[po*W +: W];
      sbq.push_back(e);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk("gnt", o_gnt, e.gnt);
      chk("oe_n", o_oe_n, e.oe_n);
      chk("busy", o_busy, e.busy);
      if (e.bus_chk) chk("bus", o_bus, e.bus);
      if (e.bq_chk) chk("bus_q", o_bq, e.bq);
   endtask

   task automatic clear_logs();
      own_log.delete();
      len_log.delete();
      gap_log.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycle('0, '0);
      cycle('0, '0);
      rst_n = 1'b1;
      clear_logs();
   endtask

   // Bus-safety monitor: at most one enable low, and a gap of at least TURNAROUND between drives.
   always @(negedge clk) begin
      if (!rst_n) begin
         gap = 1000; run_len = 0; last_g = '0;
      end else begin
         chk("onehot_oe", 64'($countones(~o_oe_n) <= 1), 64'(1));
         if (o_gnt != '0) begin
            if (last_g == '0) begin
               gap_log.push_back(gap);
               own_log.push_back($clog2(o_gnt));
               chk("turn_gap", 64'(gap >= m_ta), 64'(1));
               run_len = 0;
            end else begin
               chk("owner_switch", 64'(o_gnt), 64'(last_g));
            end
            run_len++;
         end else begin
            if (last_g != '0) len_log.push_back(run_len);
            gap = (last_g != '0) ? 1 : gap + 1;
         end
         last_g = o_gnt;
      end
   end

   initial begin
      logic [N-1:0] r;
      int exp_own[5] = '{0, 1, 2, 3, 0};

      // single requester, first grant
      sel_b = 1'b0; m_ta = 1;
      do_reset();
      cycle(4'b0001, {48'h0, 16'hA5A5});
      chk("first_bus", o_bus, 16'hA5A5);
      cycle(4'b0001, {48'h0, 16'hA5A5});

      // all four requesting: rotation with hold limit and single z cycle
      do_reset();
      for (int i = 0; i < 46; i++) cycle(4'b1111, {16'hD333, 16'hC222, 16'hB111, 16'hA000});
      chk("rr_count", 64'(own_log.size() >= 5), 64'(1));
      for (int k = 0; k < 5 && k < own_log.size(); k++) chk("rr_owner", own_log[k], exp_own[k]);
      for (int k = 0; k < 4 && k < len_log.size(); k++) chk("rr_hold", len_log[k], MH);
      for (int k = 1; k < 5 && k < gap_log.size(); k++) chk("rr_gap", gap_log[k], 1);

      // owner 2 releases early with nobody waiting
      do_reset();
      for (int i = 0; i < 3; i++) cycle(4'b0100, {16'h0, 16'h1234, 32'h0});
      cycle(4'b0000, {16'h0, 16'h1234, 32'h0});
      cycle(4'b0000, '0);
      chk("drop_len", 64'(len_log.size() > 0 ? len_log[0] : -1), 64'(3));
      cycle(4'b0000, '0);

      // reset in the middle of a drive
      do_reset();
      cycle(4'b0010, {16'h0, 16'h0, 16'h5A5A, 16'h0});
      cycle(4'b0010, {16'h0, 16'h0, 16'h5A5A, 16'h0});
      rst_n = 1'b0;
      cycle(4'b1111, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
      rst_n = 1'b1;
      clear_logs();
      cycle(4'b1111, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
      cycle(4'b1111, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
      chk("post_rst_owner", 64'(own_log.size() > 0 ? own_log[0] : -1), 64'(0));

      // three-cycle turnaround between ch1 and ch3
      sel_b = 1'b1; m_ta = 3;
      do_reset();
      cycle(4'b0010, {16'hCCCC, 16'h0, 16'hBBBB, 16'h0});
      cycle(4'b1010, {16'hCCCC, 16'h0, 16'hBBBB, 16'h0});
      cycle(4'b1010, {16'hCCCC, 16'h0, 16'hBBBB, 16'h0});
      for (int i = 0; i < 5; i++) cycle(4'b1000, {16'hCCCC, 16'h0, 16'hBBBB, 16'h0});
      chk("ta3_owners", 64'(own_log.size()), 64'(2));
      if (own_log.size() >= 2) chk("ta3_second", own_log[1], 3);
      if (gap_log.size() >= 2) chk("ta3_gap", gap_log[1], 3);

      // random traffic on both instances
      sel_b = 1'b0; m_ta = 1;
      do_reset();
      r = '0;
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(3) == 0) r = N'($urandom);
         cycle(r, {$urandom, $urandom});
      end
      sel_b = 1'b1; m_ta = 3;
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(3) == 0) r = N'($urandom);
         cycle(r, {$urandom, $urandom});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- Parametrised, multi-channel owner of a shared tristate data bus for the SimpleRISC SoC.
- Up to NCH requesters compete for one WIDTH-bit inout bus. The block arbitrates round-robin, limits hold time, and inserts guaranteed high-Z turnaround cycles between owners.
- Drives one active-low output enable per channel, so no two drivers ever overlap on the bus.

Parameters:
- WIDTH, 16, bus data width in bits (1..64)
- NCH, 4, number of requesting channels (2..16)
- TURNAROUND, 1, high-Z cycles inserted between owners (1..15)
- MAX_HOLD, 8, max consecutive drive cycles while another channel waits (2..255)

Ports:
- clk  in  1  single system clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req  in  NCH  per-channel bus request, level-sensitive
- din  in  NCH*WIDTH  per-channel drive data; channel i occupies bits [i*WIDTH +: WIDTH]
- bus  inout  WIDTH  shared tristate bus
- oe_n  out  NCH  registered active-low drive enable per channel (at most one low)
- gnt  out  NCH  registered one-hot grant (gnt[i] == ~oe_n[i])
- bus_q  out  WIDTH  bus value registered each cycle (readback)
- busy  out  1  high in DRIVE or TURN

Behaviour:
- Reset (rst_n low at edge):
  - oe_n = all 1, gnt = 0, busy = 0, bus_q = 0, state = IDLE.
  - rr_ptr = NCH-1, so channel 0 wins first; hold_cnt = 0; turn_cnt = 0.
  - Reset wins over every other event, including mid-DRIVE; the bus is high-Z from the following cycle.
- Bus drive: bus = din[owner] when state == DRIVE, else all bits 'z'. No other driver exists inside the block.
- States:
  - IDLE: bus z. If any req is high at the edge, pick the owner round-robin starting at rr_ptr+1 (wrapping at NCH). Go to DRIVE, set gnt[owner] = 1 and oe_n[owner] = 0, rr_ptr = owner, hold_cnt = 0. Latency from req to gnt is 1 cycle.
  - DRIVE: hold_cnt increments each cycle, saturating at 255.
    - Leave to TURN at the edge where req[owner] is sampled low.
    - Also leave to TURN at the edge where hold_cnt == MAX_HOLD-1 and any other req is high.
    - Otherwise stay, with no limit while no other channel requests.
    - On leaving, gnt = 0 and oe_n = all 1; load turn_cnt = TURNAROUND-1.
    - The owner must keep din valid through the cycle in which it drops req; the bus is still driven in that cycle.
  - TURN: bus z, all oe_n high. Decrement turn_cnt.
    - At the edge where turn_cnt == 0, arbitrate as in IDLE: go to DRIVE if any req, else IDLE.
    - The previous owner is eligible but has the lowest priority by rotation.
- Invariants:
  - Popcount(~oe_n) <= 1 in every cycle.
  - A change of owner always has at least TURNAROUND all-high oe_n cycles between drives.
  - The same owner re-acquiring also passes through TURN.
- Simultaneous events: if req[owner] drops and the hold expires at the same edge, take a single transition to TURN.
- Requests from channels not granted are ignored in TURN until the final TURN edge.
- bus_q <= bus every cycle (z/x is sampled as-is in simulation; the board pulls the bus to a defined level).
- No combinational path from req to oe_n or gnt.

Decomposition:
- Shared package/header:
  - State encoding localparams: IDLE = 2'd0, DRIVE = 2'd1, TURN = 2'd2.
  - Hold and turn counter widths: 8 and 4 bits.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req[NCH], rr_ptr.
  - Outputs: one-hot sel[NCH], owner index, any.
  - Reused by the IDLE and end-of-TURN paths.
- Top module: FSM, counters, and the tristate assignment.

Test Plan:
- Reset then req = 4'b0001, din0 = 16'hA5A5 → gnt = 0001 on the next edge; bus = A5A5; oe_n = 1110; busy = 1.
- req = 4'b1111 from IDLE with MAX_HOLD = 8, TURNAROUND = 1:
  - Owners are 0,1,2,3,0 in order.
  - Each owner holds 8 cycles, followed by exactly 1 z cycle with oe_n = 1111.
- Owner 2 drops req after 3 cycles with no other req → 1 TURN cycle, then IDLE; busy = 0; bus z.
- TURNAROUND = 3, ch1 owns, ch3 requests → after ch1 releases: 3 cycles of oe_n = 1111, then gnt = 1000.
- rst_n low during DRIVE of ch1 → oe_n = 1111 and bus z from the next edge. After release with req = 1111, ch0 is granted first.
- Random req/din for 10k cycles → assert popcount(~oe_n) <= 1 and the turnaround gap between owners; check bus_q equals the driven din one cycle later.
